// File: rtl/memblock_tbus_arbiter_if.sv
// Trinity-bus request/response bundle between memblock units and dcache.
// master drives the request side, slave answers with ready/done/data.
interface memblock_tbus_arbiter_if #(
  parameter int DATA_W   = 64,
  parameter int OPTYPE_W = 2
);
  logic                index_valid;
  logic                index_ready;
  logic [DATA_W-1:0]   index;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   write_mask;
  logic [OPTYPE_W-1:0] operation_type;
  logic [DATA_W-1:0]   read_data;
  logic                operation_done;

  modport master (
    output index_valid,
    output index,
    output write_data,
    output write_mask,
    output operation_type,
    input  index_ready,
    input  read_data,
    input  operation_done
  );

  modport slave (
    input  index_valid,
    input  index,
    input  write_data,
    input  write_mask,
    input  operation_type,
    output index_ready,
    output read_data,
    output operation_done
  );
endinterface

// File: rtl/memblock_tbus_arbiter.sv
// Shares the dcache tbus port between load (0) and store (1) units,
// one transaction in flight. Ports: clock, reset_n, ldu/stu (slave),
// arb2dcache (master), ldu_flush, arb_busy, arb_owner.
module memblock_tbus_arbiter #(
  parameter int DATA_W   = 64,
  parameter int OPTYPE_W = 2
) (
  input  logic clock,
  input  logic reset_n,
  memblock_tbus_arbiter_if.slave  ldu,
  memblock_tbus_arbiter_if.slave  stu,
  memblock_tbus_arbiter_if.master arb2dcache,
  input  logic ldu_flush,
  output logic arb_busy,
  output logic arb_owner
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nx;
  logic   r_owner;
  logic   w_owner_nx;
  logic   r_prio;
  logic   w_prio_nx;
  logic   r_drop;
  logic   w_drop_nx;

  logic w_win;
  logic w_req;
  logic w_kill;
  logic w_issue;
  logic w_fire;
  logic w_done;
  logic w_wait;
  logic w_out;

  // Winner: locked owner in HOLD, else single valid or prio on tie.
  always_comb begin
    w_wait = (r_state == S_WAIT);
    if (r_state == S_HOLD) begin
      w_win = r_owner;
    end else if (ldu.index_valid && stu.index_valid) begin
      w_win = r_prio;
    end else begin
      w_win = stu.index_valid;
    end
    w_req   = w_win ? stu.index_valid : ldu.index_valid;
    w_kill  = ~w_win & ldu_flush;
    w_issue = ~w_wait & w_req & ~w_kill;
    w_fire  = w_issue & arb2dcache.index_ready;
    w_done  = w_wait & arb2dcache.operation_done;
    // Pass-through paths must stay quiet while reset is held.
    w_out   = w_issue & reset_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_prio  <= w_prio_nx;
      r_drop  <= w_drop_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_prio_nx  = r_prio;
    w_drop_nx  = r_drop;
    unique case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_owner_nx = w_win;
          w_state_nx = w_fire ? S_WAIT : S_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_issue) begin
          w_state_nx = S_IDLE;
          w_owner_nx = 1'b0;
        end else if (w_fire) begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_done) begin
          w_state_nx = S_IDLE;
          w_owner_nx = 1'b0;
          w_prio_nx  = ~r_owner;
          w_drop_nx  = 1'b0;
        end else if (!r_owner && ldu_flush) begin
          w_drop_nx = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_owner_nx = 1'b0;
        w_drop_nx  = 1'b0;
      end
    endcase
  end

  always_comb begin
    arb2dcache.index_valid    = w_out;
    arb2dcache.index          = '0;
    arb2dcache.write_data     = '0;
    arb2dcache.write_mask     = '0;
    arb2dcache.operation_type = '0;
    if (w_out) begin
      arb2dcache.index          = w_win ? stu.index : ldu.index;
      arb2dcache.write_data     = w_win ? stu.write_data : ldu.write_data;
      arb2dcache.write_mask     = w_win ? stu.write_mask : ldu.write_mask;
      arb2dcache.operation_type = w_win ? stu.operation_type
                                        : ldu.operation_type;
    end
  end

  // A flushed load (now or earlier) never sees its completion.
  always_comb begin
    ldu.index_ready    = w_fire & ~w_win & reset_n;
    stu.index_ready    = w_fire & w_win & reset_n;
    ldu.operation_done = w_done & ~r_owner & ~r_drop & ~ldu_flush;
    stu.operation_done = w_done & r_owner;
    ldu.read_data      = (w_wait && !r_owner) ? arb2dcache.read_data : '0;
    stu.read_data      = (w_wait && r_owner) ? arb2dcache.read_data : '0;
    arb_busy           = (r_state != S_IDLE);
    arb_owner          = r_owner;
  end

endmodule

// File: doc/memblock_tbus_arbiter.md
Name: memblock_tbus_arbiter

Overview:
Shares the single memblock-to-dcache trinity-bus (tbus) port between the load unit (requester 0) and the store unit (requester 1). It allows at most one transaction in flight. A granted request is locked until the dcache accepts it, and ownership is held until `operation_done` returns. The block routes the done and read data back to the owner only, and absorbs completions of loads flushed by redirect.

Parameters:
- DATA_W, 64, width of tbus index, write data, write mask and read data.
- OPTYPE_W, 2, width of the tbus operation type.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ldu_tbus_index_valid  in  1  load request valid
- ldu_tbus_index_ready  out  1  load request accepted
- ldu_tbus_index  in  DATA_W  load address
- ldu_tbus_write_data  in  DATA_W  load write data (unused by dcache, forwarded)
- ldu_tbus_write_mask  in  DATA_W  load write mask
- ldu_tbus_operation_type  in  OPTYPE_W  load op type
- ldu_tbus_read_data  out  DATA_W  read data to load unit
- ldu_tbus_operation_done  out  1  completion to load unit
- ldu_flush  in  1  load unit flushed its in-flight request (memblock2dcache_flush)
- stu_tbus_index_valid, stu_tbus_index_ready, stu_tbus_index, stu_tbus_write_data, stu_tbus_write_mask, stu_tbus_operation_type, stu_tbus_read_data, stu_tbus_operation_done: same directions, widths and meanings as the ldu_ ports, for the store unit.
- arb2dcache_tbus_index_valid  out  1  request to dcache
- arb2dcache_tbus_index_ready  in  1  dcache accepts
- arb2dcache_tbus_index  out  DATA_W  muxed address
- arb2dcache_tbus_write_data  out  DATA_W  muxed write data
- arb2dcache_tbus_write_mask  out  DATA_W  muxed write mask
- arb2dcache_tbus_operation_type  out  OPTYPE_W  muxed op type
- arb2dcache_tbus_read_data  in  DATA_W  dcache read data
- arb2dcache_tbus_operation_done  in  1  dcache completion
- arb_busy  out  1  state is not IDLE
- arb_owner  out  1  registered owner (0 = load, 1 = store); 0 when IDLE

Behaviour:
- Reset: asynchronous on reset_n low; state = IDLE, owner = 0, prio = load, drop = 0.
  - All outputs are 0 during reset and while IDLE with no input valid.
- States: IDLE, HOLD (granted, not yet accepted), WAIT (accepted, awaiting done).
- Grant in IDLE:
  - Combinational, zero-latency pass-through.
  - Only one requester valid: that requester wins.
  - Both valid: the `prio` requester wins.
  - The winner's index, data, mask and optype drive arb2dcache_*, with valid = 1.
  - Loser's ready = 0.
- Requester ready = granted & arb2dcache_tbus_index_ready & state in {IDLE, HOLD}.
- IDLE transitions:
  - Fire (valid & ready): go to WAIT, owner = winner.
  - Valid without ready: go to HOLD, owner = winner.
- HOLD:
  - Only the owner is forwarded.
  - A higher-priority arrival does not preempt.
  - Fire: go to WAIT.
  - Owner drops valid, or owner = load & ldu_flush: go to IDLE with nothing issued. arb2dcache valid deasserts the same cycle.
- WAIT:
  - arb2dcache valid = 0; both readies = 0.
  - On arb2dcache_tbus_operation_done: go to IDLE and set prio = the non-owner (round-robin flip).
  - The owner's done = dcache done, unless drop = 1. The non-owner's done is always 0.
  - Owner read_data = dcache read_data; non-owner read_data = 0.
- Flush in WAIT:
  - owner = load & ldu_flush: set drop = 1, stay in WAIT until dcache done.
  - When done arrives, suppress ldu_tbus_operation_done, clear drop, go to IDLE.
  - Store requests are never dropped; ldu_flush is ignored when owner = store.
- Simultaneous events:
  - Done and new requests in the same cycle: no grant that cycle. Earliest next fire is the following cycle (1-cycle turnaround).
  - ldu_flush and done in the same WAIT cycle: done is suppressed to the load unit.
- A dcache done in IDLE or HOLD is spurious: it is ignored, no done is routed, and state is unchanged.
- A fire in HOLD or IDLE in the same cycle as ldu_flush with owner load: flush wins. No transition to WAIT, and valid to dcache is masked that cycle.

Test Plan:
- Load only, index 0x8000_0010, ready = 1:
  - same-cycle ldu ready = 1 and arb2dcache_index = 0x8000_0010;
  - dcache done 3 cycles later with data 0xDEAD_BEEF: ldu done = 1 and data 0xDEAD_BEEF, stu done = 0.
- Both valid in the same cycle after reset: load granted first. After its done, the still-valid store is granted the cycle after done (round-robin).
- Load granted with ready held 0 for 4 cycles, store asserted meanwhile: store not granted, arb2dcache index stays at the load address, arb_busy = 1, arb_owner = 0.
- Load in WAIT, ldu_flush pulse, done 2 cycles later: ldu done stays 0 and state returns to IDLE. A new load issued after done fires the next cycle.
- Load in HOLD with ldu_flush: arb2dcache valid = 0 the same cycle and state is IDLE next cycle. A pending store is then granted.
- reset_n asserted low in WAIT: all outputs are 0 immediately. After release, a dcache done is ignored with no done routed.
